// File: rtl/mpsk_modulator_if.sv
// Symbol handshake between the mapper/framer (master) and the PSK modulator (slave).
// sym_ready is driven by the slave and means "holding buffer empty".
interface mpsk_modulator_if #(
    parameter int PHASE_BITS = 2
);
    logic [PHASE_BITS-1:0] sym_in;
    logic                  sym_valid;
    logic                  sym_ready;

    modport master (output sym_in, output sym_valid, input sym_ready);
    modport slave  (input sym_in, input sym_valid, output sym_ready);
endinterface

// File: rtl/mpsk_modulator.sv
// M-ary PSK square-wave modulator: one buffered symbol selects the carrier phase,
// held for CYCLES_PER_SYM carrier periods; phase only changes at symbol boundaries.
module mpsk_modulator #(
    parameter int PHASE_BITS     = 2,
    parameter int DIV_LOG2       = 7,
    parameter int CYCLES_PER_SYM = 4,
    parameter int GRAY           = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    mpsk_modulator_if.slave        sym_if,
    output logic                   dout,
    output logic                   carrier_sync,
    output logic                   sym_start,
    output logic                   busy,
    output logic                   underrun
);
    localparam int CYC_W = (CYCLES_PER_SYM > 1) ? $clog2(CYCLES_PER_SYM) : 1;
    localparam logic [DIV_LOG2-1:0] CNT_MAX  = {DIV_LOG2{1'b1}};
    localparam logic [CYC_W-1:0]    CYC_LAST = CYC_W'(CYCLES_PER_SYM - 1);

    logic [DIV_LOG2-1:0]   cnt_q, cnt_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic                  active_q, active_d;
    logic [PHASE_BITS-1:0] phase_q, phase_d;
    logic [PHASE_BITS-1:0] buf_q, buf_d;
    logic                  buf_full_q, buf_full_d;
    logic                  loaded_q, loaded_d;
    logic                  dout_q, dout_d;
    logic                  carrier_sync_q, carrier_sync_d;
    logic                  sym_start_q, sym_start_d;
    logic                  busy_q, busy_d;
    logic                  underrun_q, underrun_d;

    logic [PHASE_BITS-1:0] buf_phase;
    logic [DIV_LOG2-1:0]   phase_offset;
    logic [DIV_LOG2-1:0]   cnt_rel;
    logic                  wave;
    logic                  at_wrap;
    logic                  boundary;
    logic                  accept;

    // Gray decode: each binary bit is the XOR of all Gray bits at or above it.
    generate
        if (GRAY != 0) begin : g_gray
            for (genvar gi = 0; gi < PHASE_BITS; gi++) begin : g_bit
                assign buf_phase[gi] = ^buf_q[PHASE_BITS-1:gi];
            end
        end else begin : g_bin
            assign buf_phase = buf_q;
        end
    endgenerate

    // Phase k shifts the high half-period by k*P/M clocks; modular subtract does the wrap.
    assign phase_offset = {phase_q, {(DIV_LOG2-PHASE_BITS){1'b0}}};
    assign cnt_rel      = cnt_q - phase_offset;
    assign wave         = ~cnt_rel[DIV_LOG2-1];

    assign sym_if.sym_ready = !buf_full_q && !reset;
    assign accept   = sym_if.sym_valid && sym_if.sym_ready;
    assign at_wrap  = (cnt_q == CNT_MAX);
    assign boundary = at_wrap && (!active_q || (cyc_q == CYC_LAST));

    always_comb begin
        cnt_d          = cnt_q + 1'b1;
        cyc_d          = cyc_q;
        active_d       = active_q;
        phase_d        = phase_q;
        buf_d          = buf_q;
        buf_full_d     = buf_full_q;
        loaded_d       = 1'b0;
        underrun_d     = 1'b0;

        if (!active_q) begin
            cyc_d = '0;
        end else if (at_wrap) begin
            cyc_d = (cyc_q == CYC_LAST) ? '0 : cyc_q + CYC_W'(1);
        end

        if (accept) begin
            buf_d      = sym_if.sym_in;
            buf_full_d = 1'b1;
        end

        // An accept can never coincide with a loading boundary: ready is low while full.
        if (boundary) begin
            if (buf_full_q) begin
                phase_d    = buf_phase;
                active_d   = 1'b1;
                buf_full_d = 1'b0;
                cyc_d      = '0;
                loaded_d   = 1'b1;
            end else begin
                active_d   = 1'b0;
                underrun_d = active_q;
            end
        end

        dout_d         = active_q && wave;
        carrier_sync_d = (cnt_q == '0);
        sym_start_d    = (cnt_q == '0) && (cyc_q == '0) && active_q && loaded_q;
        busy_d         = active_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= '0;
            cyc_q          <= '0;
            active_q       <= 1'b0;
            phase_q        <= '0;
            buf_q          <= '0;
            buf_full_q     <= 1'b0;
            loaded_q       <= 1'b0;
            dout_q         <= 1'b0;
            carrier_sync_q <= 1'b0;
            sym_start_q    <= 1'b0;
            busy_q         <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            cyc_q          <= cyc_d;
            active_q       <= active_d;
            phase_q        <= phase_d;
            buf_q          <= buf_d;
            buf_full_q     <= buf_full_d;
            loaded_q       <= loaded_d;
            dout_q         <= dout_d;
            carrier_sync_q <= carrier_sync_d;
            sym_start_q    <= sym_start_d;
            busy_q         <= busy_d;
            underrun_q     <= underrun_d;
        end
    end

    assign dout         = dout_q;
    assign carrier_sync = carrier_sync_q;
    assign sym_start    = sym_start_q;
    assign busy         = busy_q;
    assign underrun     = underrun_q;
endmodule

// File: doc/mpsk_modulator.md
Name: mpsk_modulator

Overview:
- Parametrised M-ary PSK square-wave modulator.
- Accepts one symbol per handshake into a one-entry holding buffer. Each symbol selects one of 2^PHASE_BITS equally spaced phases of a square carrier whose period is 2^DIV_LOG2 clocks, and holds it for CYCLES_PER_SYM carrier periods.
- Phase changes only on symbol boundaries.
- Output is held low when no symbol is available.
- Sits between the symbol mapper/framer and the channel output pin.

Parameters:
- PHASE_BITS, 2: bits per symbol; number of phases M = 2^PHASE_BITS. Range 1..4.
- DIV_LOG2, 7: carrier period P = 2^DIV_LOG2 clocks. Must satisfy DIV_LOG2 >= PHASE_BITS+1.
- CYCLES_PER_SYM, 4: carrier periods per symbol. Must be >= 1.
- GRAY, 1: 1 = sym_in is Gray-coded (phase = gray2bin(sym_in)); 0 = phase = sym_in.

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-high reset.
- sym_in, in, PHASE_BITS: symbol value.
- sym_valid, in, 1: sym_in valid.
- sym_ready, out, 1: holding buffer empty; symbol accepted when sym_valid && sym_ready at a rising edge.
- dout, out, 1: modulated square wave (registered).
- carrier_sync, out, 1: one-clock pulse marking the dout sample of carrier phase count 0.
- sym_start, out, 1: one-clock pulse marking the first dout sample of a new active symbol.
- busy, out, 1: a symbol is currently being transmitted (registered copy of active).
- underrun, out, 1: one-clock pulse when an active symbol ends with the buffer empty.

Behaviour:
Reset state
- Asynchronous, active-high. While reset=1:
  - cnt=0, cyc=0, active=0, phase=0, buf_full=0.
  - dout=0, carrier_sync=0, sym_start=0, busy=0, underrun=0.
  - sym_ready=0: sym_ready = !buf_full && !reset.
- Reset mid-symbol drops both the active symbol and the buffered symbol. No underrun pulse.

Counters
- cnt is DIV_LOG2 bits and increments every clock, wrapping P-1 -> 0.
- cyc counts 0..CYCLES_PER_SYM-1. It increments at each cnt wrap while active, wraps to 0, and is forced to 0 while idle.

Waveform
- S = P/M clocks per phase step.
- wave = ((cnt - phase*S) mod P) < P/2.
- Equivalent for M=4, P=128: phase 0 is high on cnt 0..63; phase 1 on 32..95; phase 2 on 64..127; phase 3 on 96..127 and 0..31.
- dout <= active && wave, registered. dout lags cnt by one clock.

Handshake / buffer
- Accept: buf <= sym_in and buf_full <= 1. sym_in is ignored when sym_ready=0.

Boundary
- A boundary occurs at any edge where cnt==P-1 and either:
  - active && cyc==CYCLES_PER_SYM-1, or
  - !active.
- At a boundary with buf_full=1: phase <= map(buf), active <= 1, buf_full <= 0, cyc <= 0.
- At a boundary with buf_full=0: active <= 0. If active was 1, pulse underrun.
- An accept on the same edge as a boundary with the buffer empty only fills the buffer. That symbol loads at the next boundary.
- No boundary occurs mid-symbol. A held buffered symbol waits for the symbol end.

Status pulses
- carrier_sync <= (cnt==0). Registered, so it aligns with dout for cnt=0.
- sym_start <= (cnt==0 && cyc==0 && active && the previous edge was a loading boundary).
- busy <= active.

Latency
- From accept while idle to the first symbol sample on dout: between 2 and P+1 clocks.
- Back-to-back symbols produce a continuous waveform with no gap when each new symbol is accepted before the current symbol's final boundary.

Test Plan:
- Reset, defaults: hold reset 3 clocks, then release with sym_valid=0 -> dout=0, sym_ready=1, busy=0; carrier_sync pulses every 128 clocks.
- Defaults, GRAY=0: accept symbols 0,1,2,3 back-to-back, each presented as soon as sym_ready rises -> each phase held for 512 clocks with high windows cnt 0..63, 32..95, 64..127, 96..31; sym_start pulses 512 clocks apart; no underrun.
- GRAY=1, PHASE_BITS=2: send sym_in=2'b11 -> phase 2 (high on cnt 64..127); send sym_in=2'b10 -> phase 3.
- Starvation: single symbol, then nothing -> after 4 carrier periods, underrun pulses once, dout returns to 0, and busy drops on the next clock.
- Backpressure: assert sym_valid continuously with a new value every accept -> sym_ready is low from the accept until the next load; no symbol is lost or duplicated (scoreboard of order).
- Small config PHASE_BITS=3, DIV_LOG2=4, CYCLES_PER_SYM=1: phase 5 -> dout high on cnt 10..15 and 0..1; then assert reset mid-symbol -> dout=0 asynchronously, and the buffered symbol is never transmitted.
